// File: rtl/cheese_collector.sv
// cheese_collector
//   Tracks N_ITEMS cheese objects against Jerry's position. Each item debounces
//   contact for DELAY_TICKS cycles before pulsing item_taken, and pulses
//   item_respawn if it sits untouched for TIMEOUT_TICKS cycles. The module keeps
//   the collected-cheese score modulo TARGET and pulses cheese_gm on wrap.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   reset         in   game restart, synchronous active-high, same effect as rst
//   pause         in   1 freezes all state and suppresses pulses
//   jerry_x/y     in   Jerry top-left corner
//   item_x/y      in   packed item corners, item i at [i*X_W +: X_W] / [i*Y_W +: Y_W]
//   item_en       in   per-item enable (item on screen and takeable)
//   item_taken    out  1-cycle pulse per item when collected
//   item_respawn  out  1-cycle pulse per item when it timed out
//   cheese_ctr    out  collected pieces modulo TARGET
//   cheese_gm     out  1-cycle pulse when TARGET is reached
module cheese_collector #(
  parameter int N_ITEMS       = 4,
  parameter int X_W           = 11,
  parameter int Y_W           = 11,
  parameter int CTR_W         = 8,
  parameter int TARGET        = 10,
  parameter int DELAY_TICKS   = 10_000,
  parameter int TIMEOUT_TICKS = 1_300_000_000,
  parameter int HOLD_DWELL    = 1,
  parameter int X_OFFSET      = 10,
  parameter int JERRY_W       = 48,
  parameter int JERRY_H       = 48,
  parameter int ITEM_W        = 32,
  parameter int ITEM_H        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reset,
  input  logic                   pause,
  input  logic [X_W-1:0]         jerry_x,
  input  logic [Y_W-1:0]         jerry_y,
  input  logic [N_ITEMS*X_W-1:0] item_x,
  input  logic [N_ITEMS*Y_W-1:0] item_y,
  input  logic [N_ITEMS-1:0]     item_en,
  output logic [N_ITEMS-1:0]     item_taken,
  output logic [N_ITEMS-1:0]     item_respawn,
  output logic [CTR_W-1:0]       cheese_ctr,
  output logic                   cheese_gm
);

  localparam int DW_RAW = $clog2(DELAY_TICKS + 1);
  localparam int DW_W   = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam int TO_RAW = $clog2(TIMEOUT_TICKS + 1);
  localparam int TO_W   = (TO_RAW < 32) ? 32 : TO_RAW;
  localparam int K_W    = $clog2(N_ITEMS + 1);
  localparam int SUM_W  = CTR_W + 4;

  localparam logic [DW_W-1:0]  DELAY_CNT = DW_W'(DELAY_TICKS);
  localparam logic [TO_W-1:0]  TO_LIM    = TO_W'(TIMEOUT_TICKS);
  localparam logic [SUM_W-1:0] TGT_E     = SUM_W'(TARGET);

  // One extra bit on every coordinate so that position + size never wraps.
  localparam logic [X_W:0] X_OFF_E   = (X_W + 1)'(X_OFFSET);
  localparam logic [X_W:0] ITEM_W_E  = (X_W + 1)'(ITEM_W);
  localparam logic [X_W:0] JERRY_W_E = (X_W + 1)'(JERRY_W);
  localparam logic [Y_W:0] ITEM_H_E  = (Y_W + 1)'(ITEM_H);
  localparam logic [Y_W:0] JERRY_H_E = (Y_W + 1)'(JERRY_H);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    COOL
  } state_t;

  state_t            state   [N_ITEMS];
  logic [DW_W-1:0]   dwell   [N_ITEMS];
  logic [TO_W-1:0]   to_cnt  [N_ITEMS];

  logic [N_ITEMS-1:0] overlap;
  logic [N_ITEMS-1:0] take_now;
  logic [K_W-1:0]     take_cnt;
  logic [SUM_W-1:0]   sum;

  // Per-item bounding-box test on the live inputs, plus the "take happens at
  // the next edge" decision. take_now already folds in pause so the item FSM
  // and the score logic agree on exactly which takes are real.
  for (genvar g = 0; g < N_ITEMS; g++) begin : g_item
    logic [X_W:0] ix;
    logic [X_W:0] jx;
    logic [Y_W:0] iy;
    logic [Y_W:0] jy;

    assign ix = {1'b0, item_x[g*X_W +: X_W]} + X_OFF_E;
    assign jx = {1'b0, jerry_x};
    assign iy = {1'b0, item_y[g*Y_W +: Y_W]};
    assign jy = {1'b0, jerry_y};

    assign overlap[g] = item_en[g]
                        && (jx < ix + ITEM_W_E) && (ix < jx + JERRY_W_E)
                        && (jy < iy + ITEM_H_E) && (iy < jy + JERRY_H_E);

    assign take_now[g] = !pause && overlap[g] && (state[g] == DWELL)
                         && (dwell[g] >= DELAY_CNT);
  end

  // Number of items collected at this edge and the resulting raw score.
  always_comb begin
    take_cnt = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      take_cnt = take_cnt + K_W'(take_now[i]);
    end
    sum = SUM_W'(cheese_ctr) + SUM_W'(take_cnt);
  end

  // Per-item state machines. Entering DWELL already counts that overlap cycle,
  // so a take lands DELAY_TICKS+1 cycles after contact starts, and a held dwell
  // count credits every earlier overlap cycle. The dwell count saturates at
  // DELAY_TICKS so a held count can never run past the take condition.
  always_ff @(posedge clk) begin
    if (rst || reset) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        state[i]  <= IDLE;
        dwell[i]  <= '0;
        to_cnt[i] <= '0;
      end
      item_taken   <= '0;
      item_respawn <= '0;
    end else begin
      item_taken   <= take_now;
      item_respawn <= '0;
      if (!pause) begin
        for (int i = 0; i < N_ITEMS; i++) begin
          if (!item_en[i]) begin
            state[i]  <= IDLE;
            dwell[i]  <= '0;
            to_cnt[i] <= '0;
          end else begin
            case (state[i])
              IDLE: begin
                if (overlap[i]) begin
                  state[i]  <= DWELL;
                  to_cnt[i] <= '0;
                  if (dwell[i] < DELAY_CNT) begin
                    dwell[i] <= dwell[i] + 1'b1;
                  end
                end else if (to_cnt[i] >= TO_LIM) begin
                  item_respawn[i] <= 1'b1;
                  to_cnt[i]       <= '0;
                end else begin
                  to_cnt[i] <= to_cnt[i] + 1'b1;
                end
              end
              DWELL: begin
                if (take_now[i]) begin
                  state[i] <= COOL;
                  dwell[i] <= '0;
                end else if (overlap[i]) begin
                  dwell[i] <= dwell[i] + 1'b1;
                end else begin
                  state[i] <= IDLE;
                  if (HOLD_DWELL == 0) begin
                    dwell[i] <= '0;
                  end
                end
              end
              COOL: begin
                if (!overlap[i]) begin
                  state[i] <= IDLE;
                end
              end
              default: state[i] <= IDLE;
            endcase
          end
        end
      end
    end
  end

  // Score keeping. Several items may be taken at the same edge; all of them
  // count, and the wrap past TARGET produces at most one cheese_gm pulse.
  always_ff @(posedge clk) begin
    if (rst || reset) begin
      cheese_ctr <= '0;
      cheese_gm  <= 1'b0;
    end else begin
      cheese_gm <= 1'b0;
      if (|take_now) begin
        if (sum >= TGT_E) begin
          cheese_ctr <= CTR_W'(sum - TGT_E);
          cheese_gm  <= 1'b1;
        end else begin
          cheese_ctr <= CTR_W'(sum);
        end
      end
    end
  end

endmodule

// File: tb/tb_cheese_collector.sv
// tb_cheese_collector
//   Self-checking bench for cheese_collector. Two instances share all inputs:
//   dut_h holds the dwell count across contact loss, dut_c clears it. Every
//   output pulse is matched against an expected-event queue per instance; a
//   geometry table exercises the collision boundaries, and hand-written
//   sequences cover dwell modes, timeout, score wrap, pause and restart.
module tb_cheese_collector;

  localparam int N    = 4;
  localparam int XW   = 11;
  localparam int YW   = 11;
  localparam int CW   = 8;
  localparam int TGT  = 10;
  localparam int DLY  = 4;
  localparam int TMO  = 20;

  typedef struct {
    int             cyc;
    logic [N-1:0]   taken;
    logic [N-1:0]   resp;
    logic [CW-1:0]  ctr;
    logic           gm;
  } sb_t;

  typedef struct {
    logic [XW-1:0] jx;
    logic [YW-1:0] jy;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic          en;
    logic          take;
    string         name;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            reset;
  logic            pause;
  logic [XW-1:0]   jerry_x;
  logic [YW-1:0]   jerry_y;
  logic [XW-1:0]   ix [N];
  logic [YW-1:0]   iy [N];
  logic [N*XW-1:0] item_x;
  logic [N*YW-1:0] item_y;
  logic [N-1:0]    item_en;

  logic [N-1:0]    taken_h, resp_h, taken_c, resp_c;
  logic [CW-1:0]   ctr_h, ctr_c;
  logic            gm_h, gm_c;

  assign item_x = {ix[3], ix[2], ix[1], ix[0]};
  assign item_y = {iy[3], iy[2], iy[1], iy[0]};

  cheese_collector #(
    .N_ITEMS(N), .X_W(XW), .Y_W(YW), .CTR_W(CW), .TARGET(TGT),
    .DELAY_TICKS(DLY), .TIMEOUT_TICKS(TMO), .HOLD_DWELL(1)
  ) dut_h (
    .clk(clk), .rst(rst), .reset(reset), .pause(pause),
    .jerry_x(jerry_x), .jerry_y(jerry_y),
    .item_x(item_x), .item_y(item_y), .item_en(item_en),
    .item_taken(taken_h), .item_respawn(resp_h),
    .cheese_ctr(ctr_h), .cheese_gm(gm_h)
  );

  cheese_collector #(
    .N_ITEMS(N), .X_W(XW), .Y_W(YW), .CTR_W(CW), .TARGET(TGT),
    .DELAY_TICKS(DLY), .TIMEOUT_TICKS(TMO), .HOLD_DWELL(0)
  ) dut_c (
    .clk(clk), .rst(rst), .reset(reset), .pause(pause),
    .jerry_x(jerry_x), .jerry_y(jerry_y),
    .item_x(item_x), .item_y(item_y), .item_en(item_en),
    .item_taken(taken_c), .item_respawn(resp_c),
    .cheese_ctr(ctr_c), .cheese_gm(gm_c)
  );

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  resp_seen = 0;
  bit  mon_on = 1'b0;
  sb_t q0[$];
  sb_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic expectEvent(input int d, input int c, input logic [N-1:0] tk,
                             input logic [N-1:0] rs, input logic [CW-1:0] ct, input logic g);
    sb_t e;
    e.cyc = c; e.taken = tk; e.resp = rs; e.ctr = ct; e.gm = g;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic expectBoth(input int c, input logic [N-1:0] tk, input logic [N-1:0] rs,
                            input logic [CW-1:0] ct, input logic g);
    expectEvent(0, c, tk, rs, ct, g);
    expectEvent(1, c, tk, rs, ct, g);
  endtask

  // Match any observed pulse against the oldest expected event of that instance;
  // an expected event whose cycle has gone by without a pulse is a miss.
  task automatic monitorDut(input int d, input logic [N-1:0] tk, input logic [N-1:0] rs,
                            input logic [CW-1:0] ct, input logic g);
    sb_t e;
    int  sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (sz > 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL dut%0d_missed_event: actual=no pulse required=pulse at cycle %0d (now %0d)",
                 d, e.cyc, cyc);
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        sz--;
      end
    end
    if (tk != '0 || rs != '0 || g) begin
      if (sz == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL dut%0d_unexpected_pulse: actual taken=%b respawn=%b gm=%b required=no pulse (cycle %0d)",
                 d, tk, rs, g, cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        checkOutput($sformatf("dut%0d_event_cycle", d), 32'(cyc), 32'(e.cyc));
        checkOutput($sformatf("dut%0d_taken", d), 32'(tk), 32'(e.taken));
        checkOutput($sformatf("dut%0d_respawn", d), 32'(rs), 32'(e.resp));
        checkOutput($sformatf("dut%0d_ctr", d), 32'(ct), 32'(e.ctr));
        checkOutput($sformatf("dut%0d_gm", d), 32'(g), 32'(e.gm));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      monitorDut(0, taken_h, resp_h, ctr_h, gm_h);
      monitorDut(1, taken_c, resp_c, ctr_c, gm_c);
      if (resp_h != '0) resp_seen++;
    end
  end

  // Waits for the next falling edge, then drives Jerry, item 0 and the enables.
  task automatic applyStimulus(input logic [XW-1:0] jx, input logic [YW-1:0] jy,
                               input logic [XW-1:0] x0, input logic [YW-1:0] y0,
                               input logic [N-1:0] en);
    @(negedge clk);
    jerry_x = jx;
    jerry_y = jy;
    ix[0]   = x0;
    iy[0]   = y0;
    item_en = en;
  endtask

  task automatic waitCycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic gameRestart();
    @(negedge clk);
    reset   = 1'b1;
    item_en = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic vec_t mkVec(input logic [XW-1:0] jx, input logic [YW-1:0] jy,
                                 input logic [XW-1:0] x0, input logic [YW-1:0] y0,
                                 input logic en, input logic take, input string nm);
    vec_t v;
    v.jx = jx; v.jy = jy; v.x0 = x0; v.y0 = y0; v.en = en; v.take = take; v.name = nm;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   n;

    // Item 0 sits at (100,100); with the x offset its box spans x 110..141,
    // so Jerry overlaps for x in 63..141 and y in 53..131.
    vecs.push_back(mkVec(11'd115,  11'd110,  11'd100,  11'd100,  1'b1, 1'b1, "geo_center"));
    vecs.push_back(mkVec(11'd141,  11'd110,  11'd100,  11'd100,  1'b1, 1'b1, "geo_right_in"));
    vecs.push_back(mkVec(11'd142,  11'd110,  11'd100,  11'd100,  1'b1, 1'b0, "geo_right_out"));
    vecs.push_back(mkVec(11'd63,   11'd110,  11'd100,  11'd100,  1'b1, 1'b1, "geo_left_in"));
    vecs.push_back(mkVec(11'd62,   11'd110,  11'd100,  11'd100,  1'b1, 1'b0, "geo_left_out"));
    vecs.push_back(mkVec(11'd115,  11'd131,  11'd100,  11'd100,  1'b1, 1'b1, "geo_bottom_in"));
    vecs.push_back(mkVec(11'd115,  11'd132,  11'd100,  11'd100,  1'b1, 1'b0, "geo_bottom_out"));
    vecs.push_back(mkVec(11'd115,  11'd53,   11'd100,  11'd100,  1'b1, 1'b1, "geo_top_in"));
    vecs.push_back(mkVec(11'd115,  11'd52,   11'd100,  11'd100,  1'b1, 1'b0, "geo_top_out"));
    vecs.push_back(mkVec(11'd2040, 11'd110,  11'd2040, 11'd100,  1'b1, 1'b1, "geo_x_nowrap"));
    vecs.push_back(mkVec(11'd115,  11'd2040, 11'd100,  11'd2040, 1'b1, 1'b1, "geo_y_nowrap"));
    vecs.push_back(mkVec(11'd115,  11'd110,  11'd100,  11'd100,  1'b0, 1'b0, "geo_disabled"));

    rst = 1'b1; reset = 1'b0; pause = 1'b0;
    for (int i = 0; i < N; i++) begin
      ix[i] = 11'd600;
      iy[i] = 11'd600;
    end
    ix[0] = 11'd100; iy[0] = 11'd100;
    jerry_x = 11'd115; jerry_y = 11'd110;
    item_en = 4'b0001;

    // Reset with overlap present, then the first take after release.
    waitCycles(2);
    checkOutput("reset_taken",   32'(taken_h), 32'd0);
    checkOutput("reset_respawn", 32'(resp_h),  32'd0);
    checkOutput("reset_ctr",     32'(ctr_h),   32'd0);
    checkOutput("reset_gm",      32'(gm_h),    32'd0);
    checkOutput("reset_ctr_c",   32'(ctr_c),   32'd0);
    mon_on = 1'b1;
    rst = 1'b0;
    n = cyc;
    expectBoth(n + DLY + 1, 4'b0001, 4'b0000, 8'd1, 1'b0);
    waitCycles(2);
    checkOutput("post_reset_quiet", 32'(taken_h), 32'd0);
    waitCycles(12);
    checkOutput("single_take_ctr", 32'(ctr_h), 32'd1);
    applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0000);

    // Collision geometry table, each vector from a fresh game.
    for (int i = 0; i < vecs.size(); i++) begin
      gameRestart();
      applyStimulus(vecs[i].jx, vecs[i].jy, vecs[i].x0, vecs[i].y0, {3'b000, vecs[i].en});
      n = cyc;
      if (vecs[i].take) expectBoth(n + DLY + 1, 4'b0001, 4'b0000, 8'd1, 1'b0);
      waitCycles(8);
      checkOutput(vecs[i].name, 32'(ctr_h), vecs[i].take ? 32'd1 : 32'd0);
      applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0000);
    end

    // Dwell modes: 3 overlap cycles, 1 break, overlap again.
    gameRestart();
    applyStimulus(11'd115, 11'd110, 11'd100, 11'd100, 4'b0001);
    n = cyc;
    waitCycles(2);
    applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0001);
    applyStimulus(11'd115, 11'd110, 11'd100, 11'd100, 4'b0001);
    expectEvent(0, n + 4 + 2, 4'b0001, 4'b0000, 8'd1, 1'b0);
    expectEvent(1, n + 4 + 5, 4'b0001, 4'b0000, 8'd1, 1'b0);
    waitCycles(12);
    checkOutput("dwell_hold_ctr",  32'(ctr_h), 32'd1);
    checkOutput("dwell_clear_ctr", 32'(ctr_c), 32'd1);
    applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0000);

    // Timeout: item 1 enabled and untouched respawns every TMO+1 cycles.
    gameRestart();
    ix[1] = 11'd500; iy[1] = 11'd500;
    resp_seen = 0;
    applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0010);
    n = cyc;
    for (int k = 1; k <= 3; k++) expectBoth(n + k * (TMO + 1), 4'b0000, 4'b0010, 8'd0, 1'b0);
    waitCycles(69);
    applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0000);
    waitCycles(40);
    checkOutput("timeout_pulses", 32'(resp_seen), 32'd3);

    // Score wrap with a simultaneous double take at cheese_ctr = 9.
    gameRestart();
    ix[2] = 11'd100; iy[2] = 11'd100;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(11'd115, 11'd110, 11'd100, 11'd100, 4'b0001);
      n = cyc;
      expectBoth(n + DLY + 1, 4'b0001, 4'b0000, CW'(k), 1'b0);
      waitCycles(6);
      applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0000);
    end
    checkOutput("pre_wrap_ctr", 32'(ctr_h), 32'd9);
    applyStimulus(11'd115, 11'd110, 11'd100, 11'd100, 4'b0101);
    n = cyc;
    expectBoth(n + DLY + 1, 4'b0101, 4'b0000, 8'd1, 1'b1);
    waitCycles(8);
    checkOutput("wrap_ctr", 32'(ctr_h), 32'd1);
    applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0000);

    // Pause for 50 cycles mid-dwell, then resume.
    gameRestart();
    applyStimulus(11'd115, 11'd110, 11'd100, 11'd100, 4'b0001);
    n = cyc;
    expectBoth(n + 2 + 50 + 3, 4'b0001, 4'b0000, 8'd1, 1'b0);
    waitCycles(2);
    pause = 1'b1;
    waitCycles(50);
    checkOutput("pause_ctr",   32'(ctr_h),   32'd0);
    checkOutput("pause_taken", 32'(taken_h), 32'd0);
    pause = 1'b0;
    waitCycles(8);
    checkOutput("pause_resume_ctr", 32'(ctr_h), 32'd1);
    applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0000);

    // Game restart mid-dwell: score clears and dwell starts over.
    applyStimulus(11'd115, 11'd110, 11'd100, 11'd100, 4'b0001);
    n = cyc;
    waitCycles(3);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    checkOutput("restart_ctr",   32'(ctr_h), 32'd0);
    checkOutput("restart_ctr_c", 32'(ctr_c), 32'd0);
    expectBoth(n + 4 + DLY + 1, 4'b0001, 4'b0000, 8'd1, 1'b0);
    waitCycles(10);
    applyStimulus(11'd300, 11'd300, 11'd100, 11'd100, 4'b0000);

    waitCycles(5);
    checkOutput("sb_drained_h", 32'(q0.size()), 32'd0);
    checkOutput("sb_drained_c", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
